tablero_2048: RTL and testbench

Board engine for the 4×4 sliding-tile game, directly downstream of the movement FSM. It consumes the FSM's 4-bit `movement` code, slides and merges the 16-cell board in the commanded direction, spawns a new tile and evaluates win/lose. It returns `flag` to the FSM, which samples it on the next move, and exposes the board to the display stage.

---
 rtl/juego_pkg.sv | 43 ++++
 rtl/linea_merge.sv | 57 +++++
 rtl/tablero_2048.sv | 190 +++++++++++++++++++
 tb/tb_tablero_2048.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/juego_pkg.sv
// Shared types and helpers for the 2048 board engine.
// Holds the move codes issued by the movement FSM, the engine state
// encoding, the cell/line types and the line-to-cell index mapping.
package juego_pkg;

  localparam logic [3:0] MOV_IZQ = 4'd1;
  localparam logic [3:0] MOV_DER = 4'd2;
  localparam logic [3:0] MOV_ARR = 4'd3;
  localparam logic [3:0] MOV_ABA = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINE0,
    ST_LINE1,
    ST_LINE2,
    ST_LINE3,
    ST_SPAWN,
    ST_CHECK,
    ST_OVER
  } estado_t;

  // Exponent of the tile held in a cell; 0 means empty.
  typedef logic [3:0] cell_t;

  // One row or column, element 0 is the edge tiles slide toward.
  typedef cell_t [0:3] linea_t;

  // Cell index {row, col} of element j of line k for a given direction.
  // 3 - j is ~j on two bits.
  function automatic logic [3:0] idx_celda(input logic [3:0] dir,
                                           input logic [1:0] k,
                                           input logic [1:0] j);
    logic [3:0] idx;
    case (dir)
      MOV_DER: idx = {k, ~j};
      MOV_ARR: idx = {j, k};
      MOV_ABA: idx = {~j, k};
      default: idx = {k, j};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/linea_merge.sv
// Combinational slide-and-merge of one 4-cell line toward element 0.
// Ports:
//   linea_in  - line before the move
//   linea_out - compacted and merged line, zero padded
//   changed   - high when linea_out differs from linea_in
module linea_merge
  import juego_pkg::*;
(
  input  linea_t linea_in,
  output linea_t linea_out,
  output logic   changed
);

  function automatic cell_t sat_inc(input cell_t e);
    return (e == 4'hF) ? 4'hF : e + 4'd1;
  endfunction

  linea_t     comp;
  logic [2:0] n;
  logic [2:0] o;
  logic       skip;

  always_comb begin
    comp = '0;
    n    = '0;
    for (int j = 0; j < 4; j++) begin
      if (linea_in[j] != '0) begin
        comp[n[1:0]] = linea_in[j];
        n = n + 3'd1;
      end
    end

    // skip marks that the element was absorbed by the previous merge,
    // so a merged tile never merges twice in one move.
    linea_out = '0;
    o         = '0;
    skip      = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != '0 && comp[j] == comp[j+1]) begin
        linea_out[o[1:0]] = sat_inc(comp[j]);
        o    = o + 3'd1;
        skip = 1'b1;
      end else begin
        linea_out[o[1:0]] = comp[j];
        o = o + 3'd1;
      end
    end
    if (!skip) begin
      linea_out[o[1:0]] = comp[3];
    end
  end

  assign changed = (linea_out != linea_in);

endmodule

// File: rtl/tablero_2048.sv
// Board engine for the 4x4 sliding-tile game.
// Accepts a move code from the movement FSM, slides/merges the four lines
// one per cycle through a shared linea_merge, spawns a tile, then updates
// the sticky win/lose flags.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   movement  - FSM code: 1 izq, 2 der, 3 arr, 4 aba; others ignored
//   board     - 16 cells, cell i at board[4i+3:4i], i = 4*row + col
//   busy      - move in progress (LINE0..CHECK)
//   win, lose - sticky end-of-game flags
//   flag      - win | lose, returned to the FSM
module tablero_2048
  import juego_pkg::*;
#(
  parameter int          WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  movement,
  output logic [63:0] board,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic        flag
);

  localparam cell_t WIN_CELL = cell_t'(WIN_EXP);

  // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  cell_t       cells [16];
  estado_t     state;
  estado_t     state_nx;
  logic [3:0]  mov_q;
  logic [3:0]  dir_q;
  logic        changed_q;
  logic [15:0] lfsr;

  logic        mov_valid;
  logic        accept;
  logic        linea_act;
  logic [1:0]  linea_k;
  linea_t      linea_in;
  linea_t      linea_out;
  logic        linea_changed;
  logic [3:0]  spawn_idx;
  logic        spawn_found;
  logic        any_win;
  logic        any_zero;
  logic        any_pair;
  logic        win_nx;
  logic        lose_nx;

  always_comb begin
    board = '0;
    for (int i = 0; i < 16; i++) begin
      board[4*i +: 4] = cells[i];
    end
  end

  assign flag      = win | lose;
  assign mov_valid = (movement >= MOV_IZQ) && (movement <= MOV_ABA);

  // Line selection: the state picks the line, the latched direction
  // picks how its elements map onto cells.
  always_comb begin
    linea_act = 1'b1;
    linea_k   = 2'd0;
    case (state)
      ST_LINE0: linea_k = 2'd0;
      ST_LINE1: linea_k = 2'd1;
      ST_LINE2: linea_k = 2'd2;
      ST_LINE3: linea_k = 2'd3;
      default:  linea_act = 1'b0;
    endcase
  end

  always_comb begin
    linea_in = '0;
    for (int j = 0; j < 4; j++) begin
      linea_in[j] = cells[idx_celda(dir_q, linea_k, 2'(j))];
    end
  end

  linea_merge u_merge (
    .linea_in  (linea_in),
    .linea_out (linea_out),
    .changed   (linea_changed)
  );

  // First empty cell scanning upward from lfsr[3:0], wrapping mod 16.
  always_comb begin
    spawn_idx   = '0;
    spawn_found = 1'b0;
    for (int off = 0; off < 16; off++) begin
      if (!spawn_found && cells[lfsr[3:0] + 4'(off)] == '0) begin
        spawn_idx   = lfsr[3:0] + 4'(off);
        spawn_found = 1'b1;
      end
    end
  end

  // End-of-game evaluation over the post-spawn board.
  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cells[i] >= WIN_CELL) any_win  = 1'b1;
      if (cells[i] == '0)       any_zero = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cells[4*r + c] == cells[4*r + c + 1]) any_pair = 1'b1;
        if (cells[4*c + r] == cells[4*c + r + 4]) any_pair = 1'b1;
      end
    end
    win_nx  = win | any_win;
    lose_nx = lose | (!any_zero && !any_pair);
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mov_valid && movement != mov_q) begin
          accept   = 1'b1;
          state_nx = ST_LINE0;
        end
      end
      ST_LINE0: state_nx = ST_LINE1;
      ST_LINE1: state_nx = ST_LINE2;
      ST_LINE2: state_nx = ST_LINE3;
      ST_LINE3: state_nx = ST_SPAWN;
      ST_SPAWN: state_nx = ST_CHECK;
      ST_CHECK: state_nx = (win_nx || lose_nx) ? ST_OVER : ST_IDLE;
      ST_OVER:  state_nx = ST_OVER;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      mov_q     <= '0;
      dir_q     <= '0;
      changed_q <= 1'b0;
      lfsr      <= LFSR_SEED;
      for (int i = 0; i < 16; i++) begin
        cells[i] <= ((i == 0) || (i == 15)) ? 4'd1 : 4'd0;
      end
    end else begin
      state <= state_nx;
      busy  <= (state_nx inside {ST_LINE0, ST_LINE1, ST_LINE2, ST_LINE3,
                                 ST_SPAWN, ST_CHECK});
      mov_q <= movement;
      lfsr  <= lfsr_next(lfsr);

      if (accept) begin
        dir_q     <= movement;
        changed_q <= 1'b0;
      end

      if (linea_act) begin
        for (int j = 0; j < 4; j++) begin
          cells[idx_celda(dir_q, linea_k, 2'(j))] <= linea_out[j];
        end
        changed_q <= changed_q | linea_changed;
      end

      if (state == ST_SPAWN && changed_q && spawn_found) begin
        cells[spawn_idx] <= 4'd1;
      end

      if (state == ST_CHECK) begin
        win  <= win_nx;
        lose <= lose_nx;
      end
    end
  end

endmodule

// File: tb/tb_tablero_2048.sv
// Bench for tablero_2048: directed scenarios plus random moves against a
// queue-based board model.
module tb_tablero_2048;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          WIN_E = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  movement = 4'd0;
  logic [63:0] board;
  logic        busy;
  logic        win;
  logic        lose;
  logic        flag;

  tablero_2048 #(.WIN_EXP(WIN_E), .LFSR_SEED(SEED)) dut (
    .clk      (clk),
    .rst      (rst),
    .movement (movement),
    .board    (board),
    .busy     (busy),
    .win      (win),
    .lose     (lose),
    .flag     (flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          mb [16];
  int          wb [16];
  bit          m_win;
  bit          m_lose;
  logic [15:0] m_lfsr;

  // Reference LFSR: new bit = x0^x2^x3^x5 inserted at the top.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else m_lfsr <= (m_lfsr >> 1) |
                   (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
  end

  function automatic int cell_idx(input int dir, input int k, input int j);
    case (dir)
      1: return 4*k + j;
      2: return 4*k + 3 - j;
      3: return 4*j + k;
      default: return 4*(3 - j) + k;
    endcase
  endfunction

  function automatic void merge_line(input int dir, input int k);
    int q[$];
    int r[$];
    int v;
    int a;
    for (int j = 0; j < 4; j++) begin
      v = wb[cell_idx(dir, k, j)];
      if (v != 0) q.push_back(v);
    end
    while (q.size() > 0) begin
      if (q.size() >= 2 && q[0] == q[1]) begin
        a = q.pop_front();
        v = q.pop_front();
        r.push_back((a + 1 > 15) ? 15 : a + 1);
      end else begin
        r.push_back(q.pop_front());
      end
    end
    for (int j = 0; j < 4; j++) begin
      wb[cell_idx(dir, k, j)] = (j < r.size()) ? r[j] : 0;
    end
  endfunction

  function automatic logic [63:0] pack_wb();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[4*i +: 4] = 4'(wb[i]);
    return p;
  endfunction

  function automatic void spawn_wb(input int s);
    int idx;
    for (int off = 0; off < 16; off++) begin
      idx = (s + off) % 16;
      if (wb[idx] == 0) begin
        wb[idx] = 1;
        return;
      end
    end
  endfunction

  function automatic bit win_wb();
    for (int i = 0; i < 16; i++) if (wb[i] >= WIN_E) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit lose_wb();
    for (int i = 0; i < 16; i++) if (wb[i] == 0) return 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (c < 3 && wb[4*r + c] == wb[4*r + c + 1]) return 1'b0;
        if (r < 3 && wb[4*r + c] == wb[4*(r + 1) + c]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mb[i] = 0;
    mb[0]  = 1;
    mb[15] = 1;
    m_win  = 1'b0;
    m_lose = 1'b0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    movement = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_board(input logic [63:0] b);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      dut.cells[i] = b[4*i +: 4];
      mb[i] = int'(b[4*i +: 4]);
    end
  endtask

  // Issues one move code for a single cycle and checks board, busy and
  // flag on every cycle through T+7 against the model.
  task automatic do_move(input logic [3:0] code, input string nm);
    logic [63:0] part [5];
    logic [63:0] fin;
    logic [63:0] exp_b;
    bit acc, chg, ow, ol, nw, nl, exp_busy, exp_flag;
    ow  = m_win;
    ol  = m_lose;
    acc = (code >= 4'd1 && code <= 4'd4) && !(m_win || m_lose);
    wb  = mb;
    part[0] = pack_wb();
    for (int k = 0; k < 4; k++) begin
      if (acc) merge_line(int'(code), k);
      part[k+1] = pack_wb();
    end
    chg = (part[4] != part[0]);
    fin = part[4];
    nw  = ow;
    nl  = ol;
    movement = code;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) movement = 4'd0;
      if (acc && c == 5) begin
        if (chg) spawn_wb(int'(m_lfsr[3:0]));
        fin = pack_wb();
        nw  = ow | win_wb();
        nl  = ol | lose_wb();
      end
      exp_b    = !acc ? part[0] : ((c <= 5) ? part[c-1] : fin);
      exp_busy = acc && (c <= 6);
      exp_flag = (c <= 6) ? (ow | ol) : (nw | nl);
      n_vec++;
      if (board !== exp_b) begin
        n_err++;
        $display("FAIL %s board cyc T+%0d: got %h want %h", nm, c, board, exp_b);
      end
      n_vec++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL %s busy cyc T+%0d: got %b want %b", nm, c, busy, exp_busy);
      end
      n_vec++;
      if (flag !== exp_flag) begin
        n_err++;
        $display("FAIL %s flag cyc T+%0d: got %b want %b", nm, c, flag, exp_flag);
      end
    end
    n_vec++;
    if (win !== nw || lose !== nl) begin
      n_err++;
      $display("FAIL %s win/lose: got %b/%b want %b/%b", nm, win, lose, nw, nl);
    end
    mb     = wb;
    m_win  = nw;
    m_lose = nl;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (board !== 64'h1000_0000_0000_0001) begin
      n_err++;
      $display("FAIL reset board: got %h want %h", board, 64'h1000_0000_0000_0001);
    end
    n_vec++;
    if ({busy, win, lose, flag} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset status: got busy/win/lose/flag %b want 0000", {busy, win, lose, flag});
    end
  endtask

  task automatic test_first_move();
    int nz;
    apply_reset();
    do_move(4'd1, "izq_from_reset");
    nz = 0;
    for (int i = 0; i < 16; i++) if (board[4*i +: 4] != 4'd0) nz++;
    n_vec++;
    if (board[3:0] !== 4'd1 || board[51:48] !== 4'd1 || nz != 3) begin
      n_err++;
      $display("FAIL first_move: got cell0=%0d cell12=%0d tiles=%0d want 1 1 3",
               board[3:0], board[51:48], nz);
    end
  endtask

  task automatic test_merge();
    logic [63:0] pats [3];
    logic [7:0]  want [3];
    pats[0] = 64'h0000_0000_0000_1111; want[0] = 8'h22;
    pats[1] = 64'h0000_0000_0000_0222; want[1] = 8'h23;
    pats[2] = 64'h0000_0000_0000_2101; want[2] = 8'h22;
    for (int p = 0; p < 3; p++) begin
      apply_reset();
      set_board(pats[p]);
      do_move(4'd1, "merge");
      n_vec++;
      if (board[7:0] !== want[p]) begin
        n_err++;
        $display("FAIL merge pat%0d cells0/1: got %h want %h", p, board[7:0], want[p]);
      end
    end
  endtask

  task automatic test_noop();
    apply_reset();
    set_board(64'h2100_2100_2100_2100);
    do_move(4'd2, "noop_der");
    n_vec++;
    if (board !== 64'h2100_2100_2100_2100 || flag !== 1'b0) begin
      n_err++;
      $display("FAIL noop: got %h flag %b want %h flag 0", board, flag, 64'h2100_2100_2100_2100);
    end
  endtask

  task automatic test_win();
    logic [63:0] frozen;
    apply_reset();
    set_board(64'h0000_0000_0000_00AA);
    do_move(4'd1, "win_izq");
    n_vec++;
    if (board[3:0] !== 4'hB || win !== 1'b1 || flag !== 1'b1) begin
      n_err++;
      $display("FAIL win: got cell0=%0d win=%b flag=%b want 11 1 1", board[3:0], win, flag);
    end
    frozen = board;
    do_move(4'd2, "win_frozen");
    n_vec++;
    if (board !== frozen) begin
      n_err++;
      $display("FAIL win_frozen: got %h want %h", board, frozen);
    end
  endtask

  task automatic test_lose();
    logic [63:0] cb;
    apply_reset();
    cb = '0;
    for (int i = 0; i < 16; i++) cb[4*i +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
    set_board(cb);
    do_move(4'd1, "lose_izq");
    n_vec++;
    if (lose !== 1'b1 || flag !== 1'b1 || win !== 1'b0 || board !== cb) begin
      n_err++;
      $display("FAIL lose: got lose=%b flag=%b win=%b board=%h want 1 1 0 %h",
               lose, flag, win, board, cb);
    end
  endtask

  task automatic test_rst_mid_move();
    int busy_cnt;
    apply_reset();
    movement = 4'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) movement = 4'd0;
      if (c == 3) rst = 1'b1;
    end
    @(negedge clk);
    n_vec++;
    if (board !== 64'h1000_0000_0000_0001 || busy !== 1'b0 || flag !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_move: got %h busy=%b flag=%b want %h 0 0",
               board, busy, flag, 64'h1000_0000_0000_0001);
    end
    rst      = 1'b0;
    movement = 4'd1;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 9) movement = 4'd0;
      if (busy) busy_cnt++;
    end
    n_vec++;
    if (busy_cnt != 6) begin
      n_err++;
      $display("FAIL held_code busy cycles: got %0d want 6", busy_cnt);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] code;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      if (m_win || m_lose) apply_reset();
      r = $urandom_range(0, 9);
      if (r < 8) code = 4'(r % 4 + 1);
      else code = 4'($urandom_range(5, 15));
      do_move(code, "random");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_first_move();
    test_merge();
    test_noop();
    test_win();
    test_lose();
    test_rst_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
